// File: rtl/pipe_ctrl.sv
// Pipeline hazard/trap controller: stage enables, bubble flushes, next-PC select, interrupt sequencing.
// Latency: outputs are combinational from state and inputs; state advances on each rising clk.
// Backpressure: mem_wait freezes all five stage registers; optional stall counter via PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_hz,
  input  logic        mem_wait,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        br_taken,
  input  logic        eret,
  input  logic        int_req,
  input  logic        int_en,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  npc_sel,
  output logic        int_ack,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MD_WAIT    = 2'd1,
    TRAP_DRAIN = 2'd2,
    TRAP_REDIR = 2'd3
  } state_t;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_TRAP = 2'd2;
  localparam logic [1:0] NPC_EPC  = 2'd3;

  state_t state_q;
  state_t state_d;
  logic   int_mask_q;
  logic   irq;

  // A new interrupt cannot be taken in the cycle right after the trap redirect.
  assign irq = int_req && int_en && !int_mask_q;

  // State register and one-cycle interrupt mask following TRAP_REDIR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      int_mask_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_mask_q <= (state_q == TRAP_REDIR);
    end
  end

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    npc_sel     = NPC_SEQ;
    int_ack     = 1'b0;

    if (!rstn) begin
      state_d  = RUN;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (irq) begin
            // Freeze the front end, bubble EX->MEM, let older ops drain.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = TRAP_DRAIN;
          end else if (eret) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            npc_sel    = NPC_EPC;
          end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else if (md_start) begin
            // A single-cycle mul/div result needs no stall at all.
            if (!md_done) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_en     = 1'b0;
              exmem_flush = 1'b1;
              state_d     = MD_WAIT;
            end
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            npc_sel    = NPC_BR;
          end else if (load_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end

        MD_WAIT: begin
          // Redirects and interrupts are not acted on here; they wait for RUN.
          if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else if (md_done) begin
            state_d = RUN;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
          end
        end

        TRAP_DRAIN: begin
          if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = TRAP_REDIR;
          end
        end

        TRAP_REDIR: begin
          // Single cycle: squash the younger stages and jump to the vector.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          npc_sel     = NPC_TRAP;
          int_ack     = 1'b1;
          state_d     = RUN;
        end

        default: state_d = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl; one vector per clock cycle.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Multi-cycle sequences (MD_WAIT, trap drain/redirect, reset abort) are ordered rows.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_hz, mem_wait, md_start, md_done, br_taken, eret, int_req, int_en;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  npc_sel;
  logic        int_ack;
  logic [31:0] stall_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rstn(rstn),
    .load_hz(load_hz), .mem_wait(mem_wait), .md_start(md_start), .md_done(md_done),
    .br_taken(br_taken), .eret(eret), .int_req(int_req), .int_en(int_en),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .npc_sel(npc_sel), .int_ack(int_ack),
    .stall_cnt(stall_cnt)
  );

  // Input bits: {load_hz, mem_wait, md_start, md_done, br_taken, eret, int_req, int_en}
  localparam logic [7:0] I_NO  = 8'h00;
  localparam logic [7:0] I_LD  = 8'h80;
  localparam logic [7:0] I_MW  = 8'h40;
  localparam logic [7:0] I_MS  = 8'h20;
  localparam logic [7:0] I_MD  = 8'h10;
  localparam logic [7:0] I_BR  = 8'h08;
  localparam logic [7:0] I_ER  = 8'h04;
  localparam logic [7:0] I_IR  = 8'h02;
  localparam logic [7:0] I_IE  = 8'h01;
  localparam logic [7:0] I_INT = 8'h03;

  // Output bits: {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush | npc_sel | int_ack}
  localparam logic [10:0] O_DEF   = 11'b11111_000_00_0;
  localparam logic [10:0] O_STALL = 11'b00011_001_00_0;
  localparam logic [10:0] O_MEMW  = 11'b00000_000_00_0;
  localparam logic [10:0] O_ERET  = 11'b11111_110_11_0;
  localparam logic [10:0] O_BR    = 11'b11111_110_01_0;
  localparam logic [10:0] O_LOAD  = 11'b00111_010_00_0;
  localparam logic [10:0] O_DRAIN = 11'b00011_001_00_0;
  localparam logic [10:0] O_REDIR = 11'b11111_111_10_1;
  localparam logic [10:0] O_RST   = 11'b00000_000_00_0;

  typedef struct {
    logic [7:0]  in;
    logic [10:0] exp;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  task automatic apply(input logic r, input logic [7:0] in, input logic [10:0] exp, input string name);
    logic [10:0] got;
    @(negedge clk);
    rstn = r;
    {load_hz, mem_wait, md_start, md_done, br_taken, eret, int_req, int_en} = in;
    if (!r) exp_cnt = '0;
    #1;
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, npc_sel, int_ack};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s outputs: got %b expected %b", name, got, exp);
    n_checks++;
    if (stall_cnt === exp_cnt) n_pass++;
    else $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, exp_cnt);
`ifdef PIPE_CTRL_PERF_CNT_EN
    if (r && !exp[10] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  initial begin
    // Run-mode events and priority
    tbl[0]  = '{I_NO, O_DEF};
    tbl[1]  = '{I_LD, O_LOAD};
    tbl[2]  = '{I_NO, O_DEF};
    tbl[3]  = '{I_BR, O_BR};
    tbl[4]  = '{I_ER, O_ERET};
    tbl[5]  = '{I_ER | I_BR, O_ERET};
    tbl[6]  = '{I_MW | I_MS | I_BR, O_MEMW};
    tbl[7]  = '{I_MS | I_MD, O_DEF};
    tbl[8]  = '{I_NO, O_DEF};
    // Mul/div wait: redirects ignored, interrupt deferred, mem_wait freezes
    tbl[9]  = '{I_MS, O_STALL};
    tbl[10] = '{I_BR | I_ER, O_STALL};
    tbl[11] = '{I_INT, O_STALL};
    tbl[12] = '{I_MW, O_MEMW};
    tbl[13] = '{I_NO, O_STALL};
    tbl[14] = '{I_MD, O_DEF};
    tbl[15] = '{I_NO, O_DEF};
    // Interrupt with mem_wait for three cycles, then drain and redirect
    tbl[16] = '{I_INT | I_MW, O_STALL};
    tbl[17] = '{I_INT | I_MW, O_MEMW};
    tbl[18] = '{I_INT | I_MW, O_MEMW};
    tbl[19] = '{I_INT, O_DRAIN};
    tbl[20] = '{I_INT | I_BR | I_ER, O_REDIR};
    tbl[21] = '{I_INT, O_DEF};
    tbl[22] = '{I_INT, O_STALL};
    tbl[23] = '{I_NO, O_DRAIN};
    tbl[24] = '{I_NO, O_REDIR};
    tbl[25] = '{I_NO, O_DEF};
    tbl[26] = '{I_IR | I_LD, O_LOAD};
    // Interrupt beats eret and branch in the same cycle
    tbl[27] = '{I_INT | I_ER | I_BR, O_STALL};
    tbl[28] = '{I_NO, O_DRAIN};
    tbl[29] = '{I_MW, O_REDIR};
    tbl[30] = '{I_ER, O_ERET};
    tbl[31] = '{I_INT | I_MW | I_MS, O_STALL};
    tbl[32] = '{I_NO, O_DRAIN};
    tbl[33] = '{I_NO, O_REDIR};
    tbl[34] = '{I_NO, O_DEF};
    tbl[35] = '{I_MS | I_BR | I_LD, O_STALL};
    tbl[36] = '{I_MD, O_DEF};
    tbl[37] = '{I_BR | I_LD | I_IE, O_BR};
    tbl[38] = '{I_LD, O_LOAD};

    rstn = 1'b0;
    {load_hz, mem_wait, md_start, md_done, br_taken, eret, int_req, int_en} = '0;
    apply(1'b0, I_NO, O_RST, "reset_state");
    apply(1'b0, I_MS | I_BR, O_RST, "reset_inputs_ignored");

    for (int i = 0; i < NV; i++) begin
      apply(1'b1, tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the middle of MD_WAIT abandons the wait; md_done afterwards is inert
    apply(1'b1, I_MS, O_STALL, "mdw_enter");
    apply(1'b1, I_NO, O_STALL, "mdw_hold");
    apply(1'b0, I_MS, O_RST, "mdw_rst_low0");
    apply(1'b0, I_NO, O_RST, "mdw_rst_low1");
    apply(1'b1, I_MD, O_DEF, "mdw_post_rst");
    apply(1'b1, I_NO, O_DEF, "mdw_post_rst2");

    // Reset during TRAP_DRAIN abandons the trap; no int_ack afterwards
    apply(1'b1, I_INT, O_STALL, "trap_enter");
    apply(1'b0, I_MW, O_RST, "trap_rst_low");
    apply(1'b1, I_NO, O_DEF, "trap_post_rst");
    apply(1'b1, I_NO, O_DEF, "trap_post_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
